hilo_muldiv_ctrl: RTL
=====================

// Module: hilo_muldiv_ctrl
// PURPOSE
//  Multi-cycle multiply/divide sequencer for MULT/MULTU/DIV/DIVU in EX.
//  Latches operands, iterates a shift-add / restoring-divide datapath and holds the pipeline via stallreq.
//  Writes the 64-bit result once through the HI/LO write port.
//  Also publishes it on a 66-bit HI/LO forwarding bus {hi_we,lo_we,hi,lo}, the same format as ex_to_id_2.
// PARAMETERS
//  STEPS_PER_CYCLE  1  iterations per clock; legal values 1,2,4; ITER = 32/STEPS_PER_CYCLE
// PORTS
//  clk           in   1   clock, all state on posedge
//  rst           in   1   asynchronous reset, active-high
//  start         in   1   EX holds a mul/div instruction this cycle
//  op            in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  src_a         in   32  rs value (multiplicand / dividend)
//  src_b         in   32  rt value (multiplier / divisor)
//  flush         in   1   cancel the in-flight operation (exception/flush)
//  stallreq      out  1   hold IF..EX
//  busy          out  1   state != IDLE
//  done          out  1   1-cycle pulse, result valid
//  hi_we, lo_we  out  1   HI/LO write enables (both = done)
//  hi_o, lo_o    out  32  result: MUL {hi,lo}=product; DIV lo=quotient, hi=remainder
//  hilo_fwd_bus  out  66  {hi_we,lo_we,hi_o,lo_o}
// BEHAVIOUR
//  Reset: state=IDLE, counter=0, all outputs 0 immediately (async), operand regs cleared.
//  FSM IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: start&!flush -> latch op, |a|, |b|, sign flags (signed ops only) -> BUSY, cnt=0.
//   BUSY: STEPS_PER_CYCLE iterations per clk, cnt++.
//    cnt==ITER-1 at edge -> DONE.
//    flush -> IDLE, no write.
//   DONE: apply sign fix, assert done/hi_we/lo_we for exactly 1 cycle -> IDLE.
//    flush in DONE suppresses the write (outputs forced 0).
//  stallreq = (IDLE & start & !flush) | BUSY. It is 0 in DONE, so EX advances on the write cycle.
//  Latency: start accepted at cycle 0; done at cycle ITER+1 (33 for default).
//  start while busy/DONE is ignored; a new start is accepted in the cycle after DONE.
//  After flush, a new start is accepted the cycle after flush.
//  hi_o/lo_o/we are 0 outside the DONE cycle. The forwarding bus is never stale.
//  Arithmetic:
//   MUL: 32x32 unsigned shift-add on magnitudes into a 64-bit accumulator.
//    Signed product negated (64-bit two's complement) when sign_a^sign_b.
//   DIV: restoring, 33-bit partial remainder; quotient negated if sign_a^sign_b.
//    Remainder takes the sign of the dividend.
//   Magnitude of 0x80000000 is held in 33 bits; no overflow trap.
//   DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
//   Divide by zero (src_b==0), both DIV and DIVU: lo=0xFFFFFFFF, hi=src_a (as latched).
//    Same latency; no exception.
//  Operand regs are not sampled after acceptance; src changes during BUSY have no effect.
// TESTING
//  1 MULTU a=FFFFFFFF b=FFFFFFFF -> done at cyc 33, hi=FFFFFFFE lo=00000001; stallreq=1 cyc 0..32.
//  2 MULT a=FFFFFFFD(-3) b=5 -> hi=FFFFFFFF lo=FFFFFFF1; DIVU a=7 b=2 -> lo=3 hi=1.
//  3 DIV a=FFFFFFF9(-7) b=2 -> lo=FFFFFFFD hi=FFFFFFFF; DIV a=7 b=FFFFFFFE -> lo=FFFFFFFD hi=1.
//  4 DIVU a=1234 b=0 -> lo=FFFFFFFF hi=1234; DIV a=80000000 b=FFFFFFFF -> lo=80000000 hi=0.
//  5 flush at cyc 10 of DIV -> no hi_we/lo_we ever, busy=0 cyc 11, start at cyc 11 accepted, done cyc 44.
//  6 rst asserted mid-BUSY (async, between edges) -> all outputs 0 at once;
//    start during BUSY ignored (result = first op only).

Source files
------------

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
// Latches operand magnitudes and signs on acceptance, runs a shift-add multiply or a
// restoring divide for ITER cycles, then writes the 64-bit result once via HI/LO.
//
// Ports:
//   clk, rst          clock (posedge), asynchronous active-high reset
//   start             EX holds a mul/div instruction this cycle
//   op                00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b      rs (multiplicand/dividend), rt (multiplier/divisor)
//   flush             cancel the in-flight operation, suppress any write
//   stallreq          hold IF..EX while accepting or iterating
//   busy              sequencer not idle
//   done              1-cycle result pulse
//   hi_we, lo_we      HI/LO write enables (equal to done)
//   hi_o, lo_o        result, zero outside the write cycle
//   hilo_fwd_bus      {hi_we, lo_we, hi_o, lo_o}
module hilo_muldiv_ctrl #(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        busy,
  output logic        done,
  output logic        hi_we,
  output logic        lo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [65:0] hilo_fwd_bus
);

  localparam int unsigned ITER = 32 / STEPS_PER_CYCLE;
  localparam int unsigned CntW = $clog2(ITER);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            div_q;     // 1: divide, 0: multiply
  logic            sa_q;      // dividend/multiplicand negative (signed ops only)
  logic            sb_q;
  logic            bz_q;      // divisor was zero
  logic [31:0]     a_q;       // raw src_a, returned as remainder on divide-by-zero
  logic [31:0]     b_mag_q;
  // Multiply: {carry, hi, lo}, multiplier consumed from bit 0.
  // Divide: {33-bit partial remainder, dividend/quotient shifting left}.
  logic [64:0]     acc_q;

  logic        sa_in, sb_in;
  logic [31:0] a_mag, b_mag;

  assign sa_in = ~op[0] & src_a[31];
  assign sb_in = ~op[0] & src_b[31];
  assign a_mag = sa_in ? -src_a : src_a;
  assign b_mag = sb_in ? -src_b : src_b;

  logic [64:0] acc_n;
  logic [32:0] shifted;
  logic [33:0] trial;
  logic [32:0] sum;
  logic [63:0] fix;

  always_comb begin
    acc_n   = acc_q;
    shifted = '0;
    trial   = '0;
    sum     = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      if (div_q) begin
        shifted = {acc_n[63:32], acc_n[31]};
        trial   = {1'b0, shifted} - {2'b00, b_mag_q};
        // Restore when the trial subtraction went negative.
        acc_n   = {(trial[33] ? shifted : trial[32:0]), acc_n[30:0], ~trial[33]};
      end else begin
        sum   = acc_n[64:32] + (acc_n[0] ? {1'b0, b_mag_q} : 33'd0);
        acc_n = {1'b0, sum, acc_n[31:1]};
      end
    end
  end

  // Sign correction applied to the final iteration's value.
  always_comb begin
    fix = acc_n[63:0];
    if (div_q) begin
      if (bz_q) begin
        fix = {a_q, 32'hFFFF_FFFF};
      end else begin
        fix[31:0]  = (sa_q ^ sb_q) ? -acc_n[31:0] : acc_n[31:0];
        fix[63:32] = sa_q ? -acc_n[63:32] : acc_n[63:32];
      end
    end else if (sa_q ^ sb_q) begin
      fix = -acc_n[63:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      a_q     <= '0;
      b_mag_q <= '0;
      acc_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !flush) begin
            state_q <= StBusy;
            cnt_q   <= '0;
            div_q   <= op[1];
            sa_q    <= sa_in;
            sb_q    <= sb_in;
            bz_q    <= (src_b == 32'd0);
            a_q     <= src_a;
            b_mag_q <= b_mag;
            // Both datapaths start from |a| in the low half (multiply commutes).
            acc_q   <= {33'd0, a_mag};
          end
        end
        StBusy: begin
          if (flush) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
            if (cnt_q == CntW'(ITER - 1)) begin
              state_q <= StDone;
              acc_q   <= {1'b0, fix};
            end else begin
              acc_q <= acc_n;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  logic wr;
  assign wr           = (state_q == StDone) && !flush;
  assign stallreq     = ((state_q == StIdle) && start && !flush) || (state_q == StBusy);
  assign busy         = (state_q != StIdle);
  assign done         = wr;
  assign hi_we        = wr;
  assign lo_we        = wr;
  assign hi_o         = wr ? acc_q[63:32] : 32'd0;
  assign lo_o         = wr ? acc_q[31:0] : 32'd0;
  assign hilo_fwd_bus = {hi_we, lo_we, hi_o, lo_o};

endmodule
